// File: rtl/prog_loader_if.sv
// Byte-stream and RAM-write signal bundle for the program loader.
// master = byte source / RAM side, slave = the loader itself.
interface prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU program RAM: START, LEN, data, CSUM.
// Holds the CPU in clear until a frame passes its checksum.
module prog_loader #(
  parameter logic [7:0] START_BYTE = 8'hA5,
  parameter int         MEM_WORDS  = 16
) (
  input  logic         clk,
  input  logic         clr,
  prog_loader_if.slave bus,
  output logic         cpu_clr,
  output logic         load_done,
  output logic         load_err
);
  localparam int ADDR_W = $clog2(MEM_WORDS);
  // One extra bit lets cnt/len hold MEM_WORDS itself without aliasing to 0.
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [7:0] MAX_LEN = 8'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [7:0]       sum;
  logic             accept;

  assign accept = bus.in_valid && bus.in_ready;

  // NOTE: all state and outputs are registered with non-blocking assignments,
  // and the reset is synchronous, so clr simply wins over any accepted byte.
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_clr       <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      cnt           <= '0;
      len           <= '0;
      sum           <= '0;
    end else begin
      bus.in_ready <= 1'b1;
      bus.mem_we   <= 1'b0;
      load_done    <= 1'b0;

      if (accept) begin
        case (state)
          IDLE, RUN: begin
            if (bus.in_data == START_BYTE) begin
              state    <= LEN;
              load_err <= 1'b0;
              cpu_clr  <= 1'b1;
              sum      <= '0;
              cnt      <= '0;
            end
          end

          LEN: begin
            if (bus.in_data != 8'd0 && bus.in_data <= MAX_LEN) begin
              len   <= bus.in_data[CNT_W-1:0];
              state <= DATA;
            end else begin
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end

          DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= cnt[ADDR_W-1:0];
            bus.mem_wdata <= bus.in_data;
            sum           <= sum + bus.in_data;
            cnt           <= cnt + 1'b1;
            if (cnt + 1'b1 == len) state <= CSUM;
          end

          CSUM: begin
            if (bus.in_data == sum) begin
              state     <= RUN;
              load_done <= 1'b1;
              cpu_clr   <= 1'b0;
            end else begin
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed-vector bench for prog_loader with a frame-level stream model.
// The model re-parses every accepted byte since the last clr each cycle.
module tb_prog_loader;
  logic clk = 1'b0;
  logic clr;
  logic cpu_clr, load_done, load_err;

  prog_loader_if #(.ADDR_W(4)) bus ();

  prog_loader #(.START_BYTE(8'hA5), .MEM_WORDS(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .cpu_clr   (cpu_clr),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Stream model state
  logic [7:0] stream[$];
  logic [7:0] vec[$];
  logic [3:0] exp_addr [256];
  logic [7:0] exp_data [256];
  int         exp_nwr, exp_done;
  bit         exp_err, exp_run;

  // Observed activity
  int         wr_seen = 0, done_seen = 0;
  int         cyc = 0, acc_cyc = -10;
  logic [3:0] last_addr;
  logic [7:0] last_data;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reading of the whole accepted stream.
  function automatic void analyse();
    int  p = 0;
    int  ln;
    bit  open = 1'b0;
    logic [7:0] s;
    exp_nwr = 0; exp_done = 0; exp_err = 1'b0; exp_run = 1'b0;
    while (p < stream.size() && !open) begin
      if (stream[p++] != 8'hA5) continue;
      exp_err = 1'b0;
      exp_run = 1'b0;
      if (p >= stream.size()) break;
      ln = int'(stream[p++]);
      if (ln < 1 || ln > 16) begin
        exp_err = 1'b1;
        continue;
      end
      s = 8'h00;
      for (int i = 0; i < ln; i++) begin
        if (p >= stream.size()) begin
          open = 1'b1;
          break;
        end
        exp_addr[exp_nwr] = 4'(i);
        exp_data[exp_nwr] = stream[p];
        exp_nwr++;
        s = s + stream[p++];
      end
      if (open || p >= stream.size()) break;
      if (stream[p++] == s) begin
        exp_run = 1'b1;
        exp_done++;
      end else begin
        exp_err = 1'b1;
      end
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      analyse();
      if (bus.mem_we) begin
        if (wr_seen < exp_nwr) begin
          check("write addr", 32'(bus.mem_addr), 32'(exp_addr[wr_seen]));
          check("write data", 32'(bus.mem_wdata), 32'(exp_data[wr_seen]));
          check("write latency", cyc, acc_cyc + 1);
        end else begin
          check("unexpected write", 32'(wr_seen), 32'(exp_nwr - 1));
        end
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
        wr_seen++;
      end
      if (load_done) done_seen++;
      check("load_done count", done_seen, exp_done);
      check("load_err", 32'(load_err), 32'(exp_err));
      check("cpu_clr", 32'(cpu_clr), 32'(!exp_run));
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      stream.push_back(b);
      acc_cyc = cyc;
    end else begin
      check("accept timeout", 32'(ok), 32'd1);
    end
    @(negedge clk);
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic feed(input bit gap);
    foreach (vec[i]) send(vec[i], gap && (i % 2 == 1));
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    stream.delete();
    wr_seen   = 0;
    done_seen = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset cpu_clr", 32'(cpu_clr), 32'd1);
    check("reset load_done", 32'(load_done), 32'd0);
    check("reset load_err", 32'(load_err), 32'd0);
    clr    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Good 3-byte frame
    vec = '{8'hA5, 8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
    feed(1'b0); settle();
    check("t1 writes", wr_seen, 3);
    check("t1 last addr", 32'(last_addr), 32'h2);
    check("t1 last data", 32'(last_data), 32'hE0);
    check("t1 done", done_seen, 1);
    check("t1 cpu_clr", 32'(cpu_clr), 32'd0);
    check("t1 load_err", 32'(load_err), 32'd0);

    // Full 16-byte frame
    vec = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) vec.push_back(8'(i));
    vec.push_back(8'h78);
    feed(1'b0); settle();
    check("t2 writes", wr_seen, 19);
    check("t2 last addr", 32'(last_addr), 32'hF);
    check("t2 last data", 32'(last_data), 32'h0F);
    check("t2 done", done_seen, 2);
    check("t2 cpu_clr", 32'(cpu_clr), 32'd0);

    // Bad checksum, then recovery with the good frame
    vec = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
    feed(1'b0); settle();
    check("t3 writes", wr_seen, 21);
    check("t3 last data", 32'(last_data), 32'h22);
    check("t3 load_err", 32'(load_err), 32'd1);
    check("t3 cpu_clr", 32'(cpu_clr), 32'd1);
    vec = '{8'hA5, 8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
    feed(1'b0); settle();
    check("t3b load_err", 32'(load_err), 32'd0);
    check("t3b cpu_clr", 32'(cpu_clr), 32'd0);
    check("t3b done", done_seen, 3);

    // Bad lengths 0 and 17
    vec = '{8'hA5, 8'h00};
    feed(1'b0); settle();
    check("t4a load_err", 32'(load_err), 32'd1);
    check("t4a writes", wr_seen, 24);
    vec = '{8'hA5, 8'h11};
    feed(1'b0); settle();
    check("t4b load_err", 32'(load_err), 32'd1);
    check("t4b writes", wr_seen, 24);
    check("t4b cpu_clr", 32'(cpu_clr), 32'd1);

    // Noise before START and in_valid gaps during data
    vec = '{8'h00, 8'hFF, 8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    feed(1'b1); settle();
    check("t5 writes", wr_seen, 28);
    check("t5 last addr", 32'(last_addr), 32'h3);
    check("t5 done", done_seen, 4);
    check("t5 load_err", 32'(load_err), 32'd0);
    check("t5 cpu_clr", 32'(cpu_clr), 32'd0);

    // START while running reasserts cpu_clr the next cycle
    send(8'hA5, 1'b0);
    bus.in_valid = 1'b0;
    check("t6 cpu_clr reassert", 32'(cpu_clr), 32'd1);
    vec = '{8'h02, 8'h05, 8'h06, 8'h0B};
    feed(1'b0); settle();
    check("t6 done", done_seen, 5);
    check("t6 cpu_clr", 32'(cpu_clr), 32'd0);

    // clr after 2 of 4 data bytes
    vec = '{8'hA5, 8'h04, 8'h10, 8'h20};
    feed(1'b0);
    pulse_clr();
    check("t7 cpu_clr", 32'(cpu_clr), 32'd1);
    check("t7 mem_we", 32'(bus.mem_we), 32'd0);
    repeat (3) @(negedge clk);
    vec = '{8'h30, 8'h40};
    feed(1'b0); settle();
    check("t7 writes after clr", wr_seen, 0);
    check("t7 load_err", 32'(load_err), 32'd0);
    check("t7 cpu_clr idle", 32'(cpu_clr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Front-end programmer for the 8-bit CPU's 16×8 program RAM: consumes a framed byte stream over a valid/ready handshake and writes it into RAM starting at address 0. It is the writer side of the memory the CPU fetches from. It holds the CPU in clear while a load is in progress and releases it only after a frame passes its checksum. It sits between the host/bench byte source and the RAM write port, and drives the CPU `clr` input.

## Interface

**Parameters**
- `START_BYTE`, default 8'hA5, frame start marker.
- `MEM_WORDS`, default 16, RAM depth; the address width is 4.

**Ports**
- `clk` in 1: single clock; all logic is rising-edge.
- `clr` in 1: synchronous, active-high reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `mem_we` out 1: RAM write strobe, one cycle per data byte.
- `mem_addr` out 4: RAM write address.
- `mem_wdata` out 8: RAM write data.
- `cpu_clr` out 1: drives the CPU's `clr`; high holds the CPU in reset.
- `load_done` out 1: one-cycle pulse on a good frame.
- `load_err` out 1: sticky error flag, cleared by `clr` or by the next accepted `START_BYTE`.

## Operation

**Frame format:** `START_BYTE`, then LEN (1..16), then LEN data bytes, then CSUM. CSUM is the 8-bit sum mod 256 of the data bytes.

**States**
- IDLE:
  - Accepted byte == `START_BYTE` → LEN. On this transition, clear `load_err`, clear `sum`, and set `cnt` to 0.
  - Any other byte is consumed and ignored.
- LEN:
  - Accepted byte in 1..16 → DATA, with `len` = byte.
  - 0 or >16 → set `load_err`, go to IDLE.
- DATA:
  - Each accepted byte is registered to `mem_wdata` with `mem_addr` = `cnt`, and `mem_we` pulses.
  - `sum` += byte (8-bit wrap); `cnt` += 1.
  - When `cnt` reaches `len`, go to CSUM.
- CSUM:
  - Accepted byte == `sum` → RUN, and pulse `load_done`.
  - Mismatch → set `load_err`, go to IDLE.
- RUN:
  - `cpu_clr` is low.
  - Accepted `START_BYTE` → LEN; `cpu_clr` reasserts and `load_err` clears.
  - Other bytes are consumed and ignored.

**`cpu_clr`** is high in every state except RUN. After a failed frame the CPU stays held, even though RAM may be partially overwritten.

**Address range:** addresses beyond `len-1` are not written. RAM contents outside the written range are unchanged.

## Timing

**Reset values**, in the cycle after `clr` is sampled high:
- state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_clr`=1, `load_done`=0, `load_err`=0.
- Internal `cnt`=0, `sum`=0, `len`=0.

**Handshake**
- `in_ready` is registered. It is 1 from the first cycle after `clr` deasserts and stays 1 in all states, so the loader accepts one byte per cycle at full rate.
- `in_valid` low stalls without any state change.

**Latencies**
- Write latency: 1 cycle. `mem_we`/`mem_addr`/`mem_wdata` are valid in the cycle after the data byte is accepted.
- Back-to-back data bytes give back-to-back `mem_we` pulses.
- `load_done` and `cpu_clr` falling both occur in the cycle after the CSUM byte is accepted.
- `load_err` rises in the cycle after the offending byte.

**Width and wrap**
- `sum` wraps mod 256.
- `cnt` is 5 bits, so it can reach 16 without aliasing; `mem_addr` = `cnt[3:0]`.

**Reset mid-frame:** `clr` high in any state returns to IDLE with reset values. No further writes are issued; a write already registered completes in that same cycle.

**Simultaneous events:** `clr` wins over an accepted byte in the same cycle.

## Test plan

- **Good 3-byte frame.** Feed A5,03,1E,2F,E0, then CSUM=2D (1E+2F+E0=0x12D → 2D).
  - Writes: addr0=1E, addr1=2F, addr2=E0, on 3 consecutive cycles.
  - `load_done` pulses once; `cpu_clr` 1→0; `load_err`=0.
- **Full 16-byte frame.** A5,10,00..0F, CSUM=78.
  - 16 writes to addr 0..F with data=addr.
  - `cnt` ends at 16 without wrapping; `cpu_clr`=0.
- **Bad checksum.** A5,02,11,22,CSUM=00.
  - Addr0=11 and addr1=22 are written.
  - `load_err`=1, `cpu_clr` stays 1, state IDLE.
  - Then the good frame from test 1 clears `load_err` and releases the CPU.
- **Bad length.** A5,00 → `load_err`=1, no `mem_we`. Separately, A5,11 → same response.
- **Stalls and noise.**
  - Garbage bytes 00,FF before A5 are ignored.
  - `in_valid` toggling 1/0 during DATA still yields writes only on accepted bytes, with the correct addresses and final checksum.
- **Reset and reload.**
  - `clr` pulsed after 2 of 4 data bytes: state returns to IDLE, `cpu_clr`=1, no further writes.
  - In RUN, an A5 reasserts `cpu_clr` in the following cycle.
